// File: rtl/match_job_sched_if.sv
// Handshake bundle for match_job_sched: requester ports, input word stream and result port.
// Optional MATCH_ABORT_EN adds the abort input and the res_aborted result flag.
interface match_job_sched_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int CNT_W  = 8,
   parameter int ID_W   = 2
);
   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] req_pattern;
   logic [NREQ*LEN_W-1:0]  req_len;
   logic [NREQ-1:0]        grant;
   logic                   in_valid;
   logic [DATA_W-1:0]      in_data;
   logic                   in_ready;
   logic                   res_valid;
   logic                   res_ready;
   logic [ID_W-1:0]        res_id;
   logic [CNT_W-1:0]       res_count;
   logic                   busy;
`ifdef MATCH_ABORT_EN
   logic                   abort;
   logic                   res_aborted;

   modport master (
      output req, req_pattern, req_len, in_valid, in_data, res_ready, abort,
      input  grant, in_ready, res_valid, res_id, res_count, busy, res_aborted
   );
   modport slave (
      input  req, req_pattern, req_len, in_valid, in_data, res_ready, abort,
      output grant, in_ready, res_valid, res_id, res_count, busy, res_aborted
   );
`else
   modport master (
      output req, req_pattern, req_len, in_valid, in_data, res_ready,
      input  grant, in_ready, res_valid, res_id, res_count, busy
   );
   modport slave (
      input  req, req_pattern, req_len, in_valid, in_data, res_ready,
      output grant, in_ready, res_valid, res_id, res_count, busy
   );
`endif
endinterface

// File: rtl/match_job_sched.sv
// Round-robin job scheduler sharing one pattern-match counter among NREQ requesters.
// Define MATCH_ABORT_EN to add the abort input and res_aborted result flag.
module match_job_sched #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int CNT_W  = 8,
   parameter int ID_W   = 2
) (
   input logic              clk,
   input logic              reset,
   match_job_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SCAN,
      REPORT
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rrPtr_q, rrPtr_d;
   logic [ID_W-1:0]     jobId_q, jobId_d;
   logic [DATA_W-1:0]   pattern_q, pattern_d;
   logic [LEN_W-1:0]    remaining_q, remaining_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic                inReady_q, inReady_d;
   logic                resValid_q, resValid_d;
   logic [ID_W-1:0]     resId_q, resId_d;
   logic [CNT_W-1:0]    resCount_q, resCount_d;
   logic                busy_q, busy_d;
`ifdef MATCH_ABORT_EN
   logic                resAborted_q, resAborted_d;
`endif

   logic                reqFound;
   logic [ID_W-1:0]     reqSel;
   logic                inFire;
   logic                isMatch;
   logic                lastWord;
   logic [CNT_W-1:0]    countInc;
   logic [CNT_W-1:0]    scanCount;

   function automatic logic [ID_W-1:0] wrapAdd(input logic [ID_W-1:0] base, input int offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= NREQ) begin
         sum = sum - NREQ;
      end
      return sum[ID_W-1:0];
   endfunction

   // First requester at or above the round-robin pointer, wrapping past the top.
   always_comb begin
      reqFound = 1'b0;
      reqSel   = rrPtr_q;
      for (int k = 0; k < NREQ; k++) begin
         if (!reqFound && bus.req[wrapAdd(rrPtr_q, k)]) begin
            reqFound = 1'b1;
            reqSel   = wrapAdd(rrPtr_q, k);
         end
      end
   end

   assign inFire    = bus.in_valid & inReady_q;
   assign isMatch   = (bus.in_data == pattern_q);
   assign lastWord  = inFire && (remaining_q == LEN_W'(1));
   assign countInc  = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
   assign scanCount = (inFire && isMatch) ? countInc : count_q;

   always_comb begin
      state_d     = state_q;
      rrPtr_d     = rrPtr_q;
      jobId_d     = jobId_q;
      pattern_d   = pattern_q;
      remaining_d = remaining_q;
      count_d     = count_q;
      grant_d     = '0;
      inReady_d   = inReady_q;
      resValid_d  = resValid_q;
      resId_d     = resId_q;
      resCount_d  = resCount_q;
`ifdef MATCH_ABORT_EN
      resAborted_d = resAborted_q;
`endif

      case (state_q)
         IDLE: begin
            if (reqFound) begin
               state_d     = LOAD;
               jobId_d     = reqSel;
               pattern_d   = bus.req_pattern[reqSel*DATA_W +: DATA_W];
               remaining_d = bus.req_len[reqSel*LEN_W +: LEN_W];
               grant_d     = NREQ'(1) << reqSel;
            end
         end

         LOAD: begin
            count_d = '0;
            if (remaining_q == '0) begin
               state_d    = REPORT;
               resValid_d = 1'b1;
               resId_d    = jobId_q;
               resCount_d = '0;
`ifdef MATCH_ABORT_EN
               resAborted_d = 1'b0;
`endif
            end else begin
               state_d   = SCAN;
               inReady_d = 1'b1;
            end
         end

         SCAN: begin
            count_d = scanCount;
            if (inFire) begin
               remaining_d = remaining_q - LEN_W'(1);
            end
`ifdef MATCH_ABORT_EN
            if (lastWord || bus.abort) begin
               resAborted_d = bus.abort;
`else
            if (lastWord) begin
`endif
               state_d    = REPORT;
               inReady_d  = 1'b0;
               resValid_d = 1'b1;
               resId_d    = jobId_q;
               resCount_d = scanCount;
            end
         end

         REPORT: begin
            if (bus.res_ready) begin
               state_d    = IDLE;
               resValid_d = 1'b0;
               rrPtr_d    = wrapAdd(jobId_q, 1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rrPtr_q     <= '0;
         jobId_q     <= '0;
         pattern_q   <= '0;
         remaining_q <= '0;
         count_q     <= '0;
         grant_q     <= '0;
         inReady_q   <= 1'b0;
         resValid_q  <= 1'b0;
         resId_q     <= '0;
         resCount_q  <= '0;
         busy_q      <= 1'b0;
`ifdef MATCH_ABORT_EN
         resAborted_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rrPtr_q     <= rrPtr_d;
         jobId_q     <= jobId_d;
         pattern_q   <= pattern_d;
         remaining_q <= remaining_d;
         count_q     <= count_d;
         grant_q     <= grant_d;
         inReady_q   <= inReady_d;
         resValid_q  <= resValid_d;
         resId_q     <= resId_d;
         resCount_q  <= resCount_d;
         busy_q      <= busy_d;
`ifdef MATCH_ABORT_EN
         resAborted_q <= resAborted_d;
`endif
      end
   end

   assign bus.grant     = grant_q;
   assign bus.in_ready  = inReady_q;
   assign bus.res_valid = resValid_q;
   assign bus.res_id    = resId_q;
   assign bus.res_count = resCount_q;
   assign bus.busy      = busy_q;
`ifdef MATCH_ABORT_EN
   assign bus.res_aborted = resAborted_q;
`endif

endmodule

// File: tb/tb_match_job_sched.sv
// Bench for match_job_sched: a full-width and a 2-bit-count instance share one stimulus,
// checked against a job-level round-robin/match-count model.
module tb_match_job_sched;

   localparam int NREQ   = 4;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 8;
   localparam int CNT_W  = 8;
   localparam int ID_W   = 2;
   localparam int SMALL_CNT_W = 2;

   logic clk = 1'b0;
   logic reset;

   int assertCount = 0;
   int failCount   = 0;
   int modelPtr    = 0;
   int abortAfter  = -1;
   logic [DATA_W-1:0] dataQ[$];
   logic [NREQ-1:0]   reqVec;

   always #5 clk = ~clk;

   match_job_sched_if #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .ID_W(ID_W)) ifM ();
   match_job_sched_if #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(SMALL_CNT_W), .ID_W(ID_W)) ifS ();

   assign ifS.req         = ifM.req;
   assign ifS.req_pattern = ifM.req_pattern;
   assign ifS.req_len     = ifM.req_len;
   assign ifS.in_valid    = ifM.in_valid;
   assign ifS.in_data     = ifM.in_data;
   assign ifS.res_ready   = ifM.res_ready;
`ifdef MATCH_ABORT_EN
   assign ifS.abort       = ifM.abort;
`endif

   match_job_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .ID_W(ID_W)) dutMain (
      .clk   (clk),
      .reset (reset),
      .bus   (ifM.slave)
   );

   match_job_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(SMALL_CNT_W), .ID_W(ID_W)) dutSmall (
      .clk   (clk),
      .reset (reset),
      .bus   (ifS.slave)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Round robin as stated: first set request scanning upward from the pointer, with wrap.
   function automatic int pickWinner(input logic [NREQ-1:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic setJob(input int slot, input logic [DATA_W-1:0] pat, input int len);
      ifM.req_pattern[slot*DATA_W +: DATA_W] = pat;
      ifM.req_len[slot*LEN_W +: LEN_W]       = LEN_W'(len);
   endtask

   // Runs one job from an idle DUT, starting and ending on a falling edge.
   task automatic applyStimulus(input logic [NREQ-1:0] reqs, input bit scramble);
      int winner;
      int remaining;
      int expCnt;
      int accepted;
      int guard;
      int waitCycles;
      bit aborted;
      logic [DATA_W-1:0] expPat;

      winner    = pickWinner(reqs, modelPtr);
      expPat    = ifM.req_pattern[winner*DATA_W +: DATA_W];
      remaining = int'(ifM.req_len[winner*LEN_W +: LEN_W]);
      expCnt    = 0;
      accepted  = 0;
      aborted   = 1'b0;
      guard     = 0;

      ifM.req = reqs;
      @(negedge clk);
      checkOutput("grant", 32'(ifM.grant), 32'(1) << winner);
      checkOutput("busy_load", 32'(ifM.busy), 32'd1);
      checkOutput("in_ready_load", 32'(ifM.in_ready), 32'd0);
      if (scramble) begin
         ifM.req         = NREQ'($urandom);
         ifM.req_pattern = $urandom;
         ifM.req_len     = $urandom;
      end
      @(negedge clk);
      checkOutput("grant_pulse", 32'(ifM.grant), 32'd0);

      while (remaining > 0 && guard < 500) begin
         checkOutput("in_ready_scan", 32'(ifM.in_ready), 32'd1);
         checkOutput("res_valid_scan", 32'(ifM.res_valid), 32'd0);
         if (dataQ.size() > 0) begin
            ifM.in_valid = 1'b1;
            ifM.in_data  = dataQ.pop_front();
         end else begin
            ifM.in_valid = 1'($urandom_range(0, 1));
            ifM.in_data  = ($urandom_range(0, 2) == 0) ? DATA_W'($urandom) : expPat;
         end
`ifdef MATCH_ABORT_EN
         ifM.abort = (abortAfter > 0 && accepted == abortAfter - 1 && ifM.in_valid);
`endif
         @(posedge clk);
         if (ifM.in_valid) begin
            accepted++;
            remaining--;
            if (ifM.in_data == expPat) expCnt++;
         end
`ifdef MATCH_ABORT_EN
         if (ifM.abort) begin
            aborted   = 1'b1;
            remaining = 0;
         end
`endif
         @(negedge clk);
         ifM.in_valid = 1'b0;
`ifdef MATCH_ABORT_EN
         ifM.abort = 1'b0;
`endif
         guard++;
      end

      waitCycles = $urandom_range(0, 5);
      for (int w = 0; w <= waitCycles; w++) begin
         checkOutput("res_valid", 32'(ifM.res_valid), 32'd1);
         checkOutput("in_ready_report", 32'(ifM.in_ready), 32'd0);
         checkOutput("res_id", 32'(ifM.res_id), 32'(winner));
         checkOutput("res_count", 32'(ifM.res_count), 32'((expCnt > 255) ? 255 : expCnt));
         checkOutput("res_id_small", 32'(ifS.res_id), 32'(winner));
         checkOutput("res_count_sat", 32'(ifS.res_count), 32'((expCnt > 3) ? 3 : expCnt));
`ifdef MATCH_ABORT_EN
         checkOutput("res_aborted", 32'(ifM.res_aborted), 32'(aborted));
`endif
         ifM.res_ready = (w == waitCycles);
         @(negedge clk);
      end
      ifM.res_ready = 1'b0;
      checkOutput("res_valid_clear", 32'(ifM.res_valid), 32'd0);
      checkOutput("busy_idle", 32'(ifM.busy), 32'd0);
      modelPtr = (winner + 1) % NREQ;
      dataQ.delete();
   endtask

   initial begin
      reset           = 1'b0;
      ifM.req         = '0;
      ifM.req_pattern = '0;
      ifM.req_len     = '0;
      ifM.in_valid    = 1'b0;
      ifM.in_data     = '0;
      ifM.res_ready   = 1'b0;
`ifdef MATCH_ABORT_EN
      ifM.abort       = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checkOutput("rst_grant", 32'(ifM.grant), 32'd0);
      checkOutput("rst_in_ready", 32'(ifM.in_ready), 32'd0);
      checkOutput("rst_res_valid", 32'(ifM.res_valid), 32'd0);
      checkOutput("rst_res_id", 32'(ifM.res_id), 32'd0);
      checkOutput("rst_res_count", 32'(ifM.res_count), 32'd0);
      checkOutput("rst_busy", 32'(ifM.busy), 32'd0);
`ifdef MATCH_ABORT_EN
      checkOutput("rst_res_aborted", 32'(ifM.res_aborted), 32'd0);
`endif
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] single job, three matches out of four words");
      setJob(0, 8'hA5, 4);
      dataQ = '{8'hA5, 8'h00, 8'hA5, 8'hA5};
      applyStimulus(4'b0001, 1'b0);

      $display("[TB] two requesters held, round robin alternation");
      setJob(0, 8'h12, 1);
      setJob(2, 8'h34, 1);
      repeat (4) applyStimulus(4'b0101, 1'b0);

      $display("[TB] zero-length job");
      setJob(1, 8'h5A, 0);
      applyStimulus(4'b0010, 1'b0);

      $display("[TB] saturating count on the narrow instance");
      setJob(3, 8'h3C, 5);
      dataQ = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
      applyStimulus(4'b1000, 1'b0);

`ifdef MATCH_ABORT_EN
      $display("[TB] abort after two of six words");
      setJob(2, 8'h77, 6);
      dataQ = '{8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77};
      abortAfter = 2;
      applyStimulus(4'b0100, 1'b0);
      abortAfter = -1;
`endif

      $display("[TB] randomized jobs");
      for (int j = 0; j < 40; j++) begin
         for (int s = 0; s < NREQ; s++) begin
            setJob(s, DATA_W'($urandom), ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 9)));
         end
         reqVec = NREQ'($urandom_range(1, 15));
         applyStimulus(reqVec, 1'b1);
      end

      $display("[TB] reset in the middle of a scan");
      setJob(1, 8'h11, 6);
      ifM.req = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      ifM.in_valid = 1'b1;
      ifM.in_data  = 8'h11;
      @(negedge clk);
      @(negedge clk);
      checkOutput("in_ready_pre_reset", 32'(ifM.in_ready), 32'd1);
      reset        = 1'b0;
      ifM.req      = '0;
      ifM.in_valid = 1'b0;
      #1;
      checkOutput("reset_in_ready", 32'(ifM.in_ready), 32'd0);
      checkOutput("reset_busy", 32'(ifM.busy), 32'd0);
      checkOutput("reset_res_valid", 32'(ifM.res_valid), 32'd0);
      @(negedge clk);
      reset    = 1'b1;
      modelPtr = 0;
      repeat (4) begin
         @(negedge clk);
         checkOutput("no_result_after_reset", 32'(ifM.res_valid), 32'd0);
         checkOutput("idle_after_reset", 32'(ifM.busy), 32'd0);
      end
      setJob(0, 8'h01, 2);
      setJob(1, 8'h02, 2);
      setJob(2, 8'h03, 2);
      setJob(3, 8'h04, 2);
      applyStimulus(4'b1111, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
